commit_trace_checker: RTL and testbench

- Synthesizable checker that consumes the processor's per-instruction commit stream and compares it, in order, against expected commit records preloaded from a golden trace.
- Expected records enter through a ready/valid port into an internal FIFO. Commits arrive one per cycle on a valid-qualified port.
- Reports a sticky pass/fail status, the failing instruction number and PC, and a running instruction count.
- Sits beside the processor in the hierarchy bench and self-checks without text trace diffing.

---
 rtl/commit_trace_checker.sv | 179 +++++++++++++++++
 tb/tb_commit_trace_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// ============================================================================
// Module   : commit_trace_checker
// Purpose  : In-order checker of retired instructions against a preloaded golden trace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [15:0]      exp_pc,
    input  logic             exp_reg_wrt,
    input  logic [2:0]       exp_reg,
    input  logic [15:0]      exp_reg_data,
    input  logic             exp_mem_rd,
    input  logic             exp_mem_wrt,
    input  logic [15:0]      exp_mem_addr,
    input  logic [15:0]      exp_mem_data,
    input  logic             exp_halt,
    input  logic             cmt_valid,
    input  logic [15:0]      cmt_pc,
    input  logic             cmt_reg_wrt,
    input  logic [2:0]       cmt_reg,
    input  logic [15:0]      cmt_reg_data,
    input  logic             cmt_mem_rd,
    input  logic             cmt_mem_wrt,
    input  logic [15:0]      cmt_mem_addr,
    input  logic [15:0]      cmt_mem_data,
    input  logic             cmt_halt,
    output logic             done,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] fail_inum,
    output logic [15:0]      fail_pc
);

    localparam int               c_AW    = $clog2(DEPTH);
    localparam int               c_REC_W = 71;
    localparam logic [c_AW:0]    c_FULL  = (c_AW + 1)'(DEPTH);
    localparam logic [1:0]       c_RUN    = 2'd0;
    localparam logic [1:0]       c_HALTED = 2'd1;
    localparam logic [1:0]       c_FAIL   = 2'd2;

    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]    r_wrPtr, r_rdPtr;
    logic [c_AW:0]      r_count, w_nextCount;
    logic               r_expReady;
    logic [1:0]         r_state, w_nextState;
    logic [2:0]         r_errCode, w_errCode;
    logic [CNT_W-1:0]   r_instCount, r_failInum;
    logic [15:0]        r_failPc;
    logic               w_push, w_pop, w_evaluate, w_empty, w_mismatch, w_lastRec;
    logic               w_done, w_fail;

    logic [c_REC_W-1:0] w_expRec, w_head;
    logic [15:0]        w_hPc, w_hRegData, w_hMemAddr, w_hMemData;
    logic [2:0]         w_hReg;
    logic               w_hRegWrt, w_hMemRd, w_hMemWrt, w_hHalt;

    assign w_expRec = {exp_pc, exp_reg_wrt, exp_reg, exp_reg_data, exp_mem_rd,
                       exp_mem_wrt, exp_mem_addr, exp_mem_data, exp_halt};
    assign w_head   = r_mem[r_rdPtr];
    assign {w_hPc, w_hRegWrt, w_hReg, w_hRegData, w_hMemRd,
            w_hMemWrt, w_hMemAddr, w_hMemData, w_hHalt} = w_head;

    assign w_empty    = (r_count == '0);
    assign w_lastRec  = (r_count == (c_AW + 1)'(1));
    assign w_push     = exp_valid & r_expReady;
    assign w_evaluate = (r_state == c_RUN) & cmt_valid;
    assign w_pop      = w_evaluate & ~w_empty;

    always_comb begin
        w_nextCount = r_count;
        if (w_push && !w_pop)
            w_nextCount = r_count + (c_AW + 1)'(1);
        else if (!w_push && w_pop)
            w_nextCount = r_count - (c_AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= w_expRec;
    end

    // Ready is registered from the next count so a full FIFO never accepts a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_expReady <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_AW'(1);
            r_count    <= w_nextCount;
            r_expReady <= (w_nextCount != c_FULL);
        end
    end

    always_comb begin
        w_errCode = 3'd0;
        if (w_empty)
            w_errCode = 3'd5;
        else if ((cmt_reg_wrt != w_hRegWrt) || (cmt_mem_rd != w_hMemRd) ||
                 (cmt_mem_wrt != w_hMemWrt) || (cmt_halt != w_hHalt))
            w_errCode = 3'd4;
        else if (cmt_pc != w_hPc)
            w_errCode = 3'd1;
        else if (w_hRegWrt && ((cmt_reg != w_hReg) || (cmt_reg_data != w_hRegData)))
            w_errCode = 3'd2;
        else if (((w_hMemRd || w_hMemWrt) && (cmt_mem_addr != w_hMemAddr)) ||
                 (w_hMemWrt && (cmt_mem_data != w_hMemData)))
            w_errCode = 3'd3;
    end

    assign w_mismatch = (w_errCode != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_RUN;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (w_evaluate) begin
            if (w_mismatch)
                w_nextState = c_FAIL;
            else if (w_hHalt)
                w_nextState = w_lastRec ? c_HALTED : c_FAIL;
        end
    end

    always_comb begin
        w_done = (r_state == c_HALTED);
        w_fail = (r_state == c_FAIL);
    end

    // A matching halt with records left over counts as retired but still fails the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCode   <= 3'd0;
            r_instCount <= '0;
            r_failInum  <= '0;
            r_failPc    <= 16'd0;
        end else if (w_evaluate) begin
            if (w_mismatch) begin
                r_errCode  <= w_errCode;
                r_failInum <= r_instCount;
                r_failPc   <= cmt_pc;
            end else begin
                r_instCount <= r_instCount + CNT_W'(1);
                if (w_hHalt && !w_lastRec) begin
                    r_errCode  <= 3'd6;
                    r_failInum <= r_instCount;
                    r_failPc   <= cmt_pc;
                end
            end
        end
    end

    assign exp_ready  = r_expReady;
    assign done       = w_done;
    assign fail       = w_fail;
    assign err_code   = r_errCode;
    assign inst_count = r_instCount;
    assign fail_inum  = r_failInum;
    assign fail_pc    = r_failPc;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_checker.sv
// ============================================================================
// Module   : tb_commit_trace_checker
// Purpose  : Directed self-checking bench for commit_trace_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_valid = 1'b0, exp_ready;
    logic [15:0] exp_pc = '0, exp_reg_data = '0, exp_mem_addr = '0, exp_mem_data = '0;
    logic        exp_reg_wrt = 1'b0, exp_mem_rd = 1'b0, exp_mem_wrt = 1'b0, exp_halt = 1'b0;
    logic [2:0]  exp_reg = '0;
    logic        cmt_valid = 1'b0;
    logic [15:0] cmt_pc = '0, cmt_reg_data = '0, cmt_mem_addr = '0, cmt_mem_data = '0;
    logic        cmt_reg_wrt = 1'b0, cmt_mem_rd = 1'b0, cmt_mem_wrt = 1'b0, cmt_halt = 1'b0;
    logic [2:0]  cmt_reg = '0;
    logic        done, fail;
    logic [2:0]  err_code;
    logic [15:0] inst_count, fail_inum, fail_pc;

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc),
        .exp_reg_wrt(exp_reg_wrt), .exp_reg(exp_reg), .exp_reg_data(exp_reg_data),
        .exp_mem_rd(exp_mem_rd), .exp_mem_wrt(exp_mem_wrt), .exp_mem_addr(exp_mem_addr),
        .exp_mem_data(exp_mem_data), .exp_halt(exp_halt),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_reg_wrt(cmt_reg_wrt),
        .cmt_reg(cmt_reg), .cmt_reg_data(cmt_reg_data), .cmt_mem_rd(cmt_mem_rd),
        .cmt_mem_wrt(cmt_mem_wrt), .cmt_mem_addr(cmt_mem_addr),
        .cmt_mem_data(cmt_mem_data), .cmt_halt(cmt_halt),
        .done(done), .fail(fail), .err_code(err_code), .inst_count(inst_count),
        .fail_inum(fail_inum), .fail_pc(fail_pc)
    );

    task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setExp(input logic [15:0] pc, input logic rw, input logic [2:0] rg,
                          input logic [15:0] rd, input logic mr, input logic mw,
                          input logic [15:0] ma, input logic [15:0] md, input logic h);
        {exp_pc, exp_reg_wrt, exp_reg, exp_reg_data} = {pc, rw, rg, rd};
        {exp_mem_rd, exp_mem_wrt, exp_mem_addr, exp_mem_data, exp_halt} = {mr, mw, ma, md, h};
    endtask

    task automatic setCmt(input logic [15:0] pc, input logic rw, input logic [2:0] rg,
                          input logic [15:0] rd, input logic mr, input logic mw,
                          input logic [15:0] ma, input logic [15:0] md, input logic h);
        {cmt_pc, cmt_reg_wrt, cmt_reg, cmt_reg_data} = {pc, rw, rg, rd};
        {cmt_mem_rd, cmt_mem_wrt, cmt_mem_addr, cmt_mem_data, cmt_halt} = {mr, mw, ma, md, h};
    endtask

    task automatic pushRec(input logic [15:0] pc, input logic rw, input logic [2:0] rg,
                           input logic [15:0] rd, input logic mr, input logic mw,
                           input logic [15:0] ma, input logic [15:0] md, input logic h);
        setExp(pc, rw, rg, rd, mr, mw, ma, md, h);
        exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic commitRec(input logic [15:0] pc, input logic rw, input logic [2:0] rg,
                             input logic [15:0] rd, input logic mr, input logic mw,
                             input logic [15:0] ma, input logic [15:0] md, input logic h);
        setCmt(pc, rw, rg, rd, mr, mw, ma, md, h);
        cmt_valid = 1'b1;
        tick();
        cmt_valid = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        exp_valid = 1'b0;
        cmt_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic loadGolden();
        pushRec(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
        pushRec(16'h0002, 0, 3'd0, 16'h0000, 0, 1, 16'h0010, 16'h0005, 0);
        pushRec(16'h0004, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
    endtask

    initial begin
        // Reset values while rst is held
        tick();
        chkEq("rst_ready", exp_ready, 0);
        chkEq("rst_done", done, 0);
        chkEq("rst_fail", fail, 0);
        chkEq("rst_err", err_code, 0);
        chkEq("rst_icnt", inst_count, 0);
        chkEq("rst_inum", fail_inum, 0);
        chkEq("rst_fpc", fail_pc, 0);

        // Clean golden run
        resetDut();
        chkEq("ready_idle", exp_ready, 1);
        loadGolden();
        commitRec(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0002, 0, 3'd0, 16'h0000, 0, 1, 16'h0010, 16'h0005, 0);
        chkEq("good_done_pre", done, 0);
        chkEq("good_icnt_pre", inst_count, 2);
        commitRec(16'h0004, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        chkEq("good_done", done, 1);
        chkEq("good_fail", fail, 0);
        chkEq("good_icnt", inst_count, 3);

        // Bad store data on the second commit
        resetDut();
        loadGolden();
        commitRec(16'h0000, 1, 3'd1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0002, 0, 3'd0, 16'h0000, 0, 1, 16'h0010, 16'h0006, 0);
        chkEq("st_fail", fail, 1);
        chkEq("st_err", err_code, 3);
        chkEq("st_inum", fail_inum, 1);
        chkEq("st_fpc", fail_pc, 16'h0002);
        chkEq("st_icnt", inst_count, 1);
        commitRec(16'h0004, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        chkEq("st_ign_done", done, 0);
        chkEq("st_ign_icnt", inst_count, 1);
        chkEq("st_ign_err", err_code, 3);

        // Commit with nothing preloaded
        resetDut();
        commitRec(16'h0000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("uf_fail", fail, 1);
        chkEq("uf_err", err_code, 5);
        chkEq("uf_inum", fail_inum, 0);

        // Priority and don't-care fields
        resetDut();
        pushRec(16'h0020, 1, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0022, 0, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("prio_flag", err_code, 4);
        resetDut();
        pushRec(16'h0020, 1, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0022, 1, 3'd4, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("prio_pc", err_code, 1);
        resetDut();
        pushRec(16'h0020, 1, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0020, 1, 3'd4, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("reg_err", err_code, 2);
        resetDut();
        pushRec(16'h0030, 0, 3'd5, 16'hAAAA, 0, 0, 16'hBBBB, 16'hCCCC, 0);
        commitRec(16'h0030, 0, 3'd2, 16'h5555, 0, 0, 16'h1111, 16'h2222, 0);
        chkEq("dc_fail", fail, 0);
        chkEq("dc_icnt", inst_count, 1);

        // Full FIFO: simultaneous push is rejected while the pop goes through
        resetDut();
        for (int i = 0; i < 8; i++)
            pushRec(16'(i * 2), 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("full_ready", exp_ready, 0);
        setExp(16'h0100, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        setCmt(16'h0000, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        exp_valid = 1'b1;
        cmt_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
        cmt_valid = 1'b0;
        chkEq("full_ready_after", exp_ready, 1);
        chkEq("full_icnt1", inst_count, 1);
        for (int i = 1; i < 8; i++)
            commitRec(16'(i * 2), 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("full_drain_fail", fail, 0);
        chkEq("full_drain_icnt", inst_count, 8);
        commitRec(16'h0100, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("full_rej_fail", fail, 1);
        chkEq("full_rej_err", err_code, 5);
        chkEq("full_rej_inum", fail_inum, 8);

        // Halt matches but records remain
        resetDut();
        pushRec(16'h0040, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        pushRec(16'h0042, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0040, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        chkEq("early_halt_fail", fail, 1);
        chkEq("early_halt_err", err_code, 6);
        chkEq("early_halt_done", done, 0);

        // Asynchronous reset mid-run with records queued
        resetDut();
        for (int i = 0; i < 6; i++)
            pushRec(16'(16'h0050 + i * 2), 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0050, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        commitRec(16'h0099, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("ar_pre_fail", fail, 1);
        chkEq("ar_pre_err", err_code, 1);
        chkEq("ar_pre_fpc", fail_pc, 16'h0099);
        chkEq("ar_pre_icnt", inst_count, 1);
        #2 rst = 1'b1;
        #1;
        chkEq("ar_fail", fail, 0);
        chkEq("ar_err", err_code, 0);
        chkEq("ar_icnt", inst_count, 0);
        chkEq("ar_fpc", fail_pc, 0);
        chkEq("ar_ready", exp_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        commitRec(16'h0054, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        chkEq("ar_post_err", err_code, 5);
        chkEq("ar_post_fail", fail, 1);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

`default_nettype wire
